// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StStart,
        StBit,
        StAck,
        StStop,
        StGap,
        StDone,
        StErr
    } state_e;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;

    localparam int unsigned I2C_BYTES_PER_WORD = 3;
    localparam int unsigned BIT_PERIOD_TICKS   = 4;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator: one-cycle pulse every CLK_DIV system cycles.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    assign tick = !clr && (cnt_q == TERM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Write-only I2C master that streams N_WORDS table words to a 7-bit slave as
// 3-byte writes, retrying NACKed words up to MAX_RETRY times.
module i2c_cfg_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned N_WORDS   = 10,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned CLK_DIV   = 125,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned AW        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic [AW-1:0] o_rom_addr,
    input  logic [15:0]   i_rom_data,
    output logic          o_busy,
    output logic          o_finished,
    output logic          o_error,
    output logic [AW-1:0] o_fail_idx,
    output logic          o_I2C_SCLK,
    inout  wire           i2c_sdat,
    output logic          o_i2c_oen
);

    localparam logic [AW-1:0] LAST_IDX    = AW'(N_WORDS - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [1:0]    LAST_BYTE   = 2'(I2C_BYTES_PER_WORD - 1);
    localparam phase_e        LAST_PHASE  = phase_e'(2'(BIT_PERIOD_TICKS - 1));

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic          fetch_sub_q, fetch_sub_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    retry_q, retry_d;
    logic          fail_q, fail_d;
    logic [23:0]   sr_q, sr_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic          error_q, error_d;
    logic [AW-1:0] fail_idx_q, fail_idx_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          oen_q, oen_d;

    logic tick, tick_clr, bit_end;

    assign tick_clr = (state_q == StIdle) || (state_q == StFetch) ||
                      (state_q == StDone) || (state_q == StErr);

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (tick_clr),
        .tick    (tick)
    );

    assign bit_end = tick && (phase_q == LAST_PHASE);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        fetch_sub_d = fetch_sub_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        fail_d      = fail_q;
        sr_d        = sr_q;
        busy_d      = busy_q;
        finished_d  = finished_q;
        error_d     = error_q;
        fail_idx_d  = fail_idx_q;

        if (tick) begin
            phase_d = phase_e'(phase_q + 2'd1);
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d     = StFetch;
                    fetch_sub_d = 1'b0;
                    idx_d       = '0;
                    retry_d     = '0;
                    busy_d      = 1'b1;
                    finished_d  = 1'b0;
                    error_d     = 1'b0;
                end
            end
            // Cycle 0 presents the address, cycle 1 captures the table word.
            StFetch: begin
                if (!fetch_sub_q) begin
                    fetch_sub_d = 1'b1;
                end else begin
                    fetch_sub_d = 1'b0;
                    sr_d        = {DEV_ADDR, 1'b0, i_rom_data};
                    phase_d     = Q0;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    fail_d      = 1'b0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StBit;
                end
            end
            StBit: begin
                if (bit_end) begin
                    sr_d = {sr_q[22:0], 1'b0};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = StAck;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StAck: begin
                if (tick && (phase_q == Q2)) begin
                    fail_d = i2c_sdat;
                end
                if (bit_end) begin
                    if (fail_q || (byte_cnt_q == LAST_BYTE)) begin
                        state_d = StStop;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = StBit;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (bit_end) begin
                    if (!fail_q) begin
                        if (idx_q == LAST_IDX) begin
                            state_d    = StDone;
                            finished_d = 1'b1;
                            busy_d     = 1'b0;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = '0;
                            state_d = StFetch;
                        end
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 4'd1;
                        state_d = StFetch;
                    end else begin
                        state_d    = StErr;
                        error_d    = 1'b1;
                        fail_idx_d = idx_q;
                        busy_d     = 1'b0;
                    end
                end
            end
            StDone, StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus levels are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        oen_d = 1'b1;
        unique case (state_d)
            StStart: begin
                scl_d = (phase_d != Q3);
                sda_d = (phase_d == Q0);
            end
            StBit: begin
                scl_d = (phase_d == Q1) || (phase_d == Q2);
                sda_d = sr_d[23];
            end
            StAck: begin
                scl_d = (phase_d == Q1) || (phase_d == Q2);
                oen_d = 1'b0;
            end
            StStop: begin
                scl_d = (phase_d != Q0);
                sda_d = (phase_d == Q2) || (phase_d == Q3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            phase_q     <= Q0;
            fetch_sub_q <= 1'b0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            fail_q      <= 1'b0;
            sr_q        <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            fail_idx_q  <= '0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            oen_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            fetch_sub_q <= fetch_sub_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            fail_q      <= fail_d;
            sr_q        <= sr_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
            fail_idx_q  <= fail_idx_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            oen_q       <= oen_d;
        end
    end

    assign i2c_sdat   = oen_q ? sda_q : 1'bz;
    assign o_rom_addr = idx_q;
    assign o_busy     = busy_q;
    assign o_finished = finished_q;
    assign o_error    = error_q;
    assign o_fail_idx = fail_idx_q;
    assign o_I2C_SCLK = scl_q;
    assign o_i2c_oen  = oen_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench: bus monitor decodes frames, scoreboard compares bytes against a queue.
module tb_i2c_cfg_sequencer;

    localparam int unsigned CLK_DIV   = 4;
    localparam logic [7:0]  ADDR_BYTE = {7'h1A, 1'b0};
    localparam int          CLEAN_LAT = 2 * (2 + 4 * CLK_DIV * 30);
    localparam int          FAIL_ATT  = 2 + 4 * CLK_DIV * 21;
    localparam int          BOUND     = 5000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [0:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy, finished, error;
    logic [0:0]  fail_idx;
    logic        scl, oen;
    wire         sda;

    logic [15:0] tbl [2];
    logic [7:0]  exp_q [$];

    int   checks   = 0;
    int   failures = 0;

    // Monitor / slave state
    logic prev_scl, prev_sda, prev_oen;
    bit   in_frame;
    int   bitcnt, byte_idx, frame_idx, mode;
    logic [7:0] shreg;
    bit   nacked_once;
    logic slave_nack = 1'b0;

    i2c_cfg_sequencer #(
        .N_WORDS   (2),
        .DEV_ADDR  (7'h1A),
        .CLK_DIV   (CLK_DIV),
        .MAX_RETRY (2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_busy     (busy),
        .o_finished (finished),
        .o_error    (error),
        .o_fail_idx (fail_idx),
        .o_I2C_SCLK (scl),
        .i2c_sdat   (sda),
        .o_i2c_oen  (oen)
    );

    assign sda = oen ? 1'bz : slave_nack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) rom_data <= tbl[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int i);
        exp_q.push_back(ADDR_BYTE);
        exp_q.push_back(tbl[i][15:8]);
        exp_q.push_back(tbl[i][7:0]);
    endtask

    task automatic byte_done();
        logic nack;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("bus_byte", shreg, exp_q.pop_front());
        nack = 1'b0;
        if (mode == 1 && byte_idx == 1 && !nacked_once) begin
            nack = 1'b1;
            nacked_once = 1'b1;
        end
        if (mode == 2 && byte_idx == 0 && frame_idx >= 1) nack = 1'b1;
        slave_nack = nack;
    endtask

    task automatic step();
        logic s_scl, s_sda, s_oen;
        @(negedge clk);
        s_scl = scl;
        s_sda = sda;
        s_oen = oen;
        if (prev_scl && s_scl && (prev_sda !== s_sda)) begin
            if (!s_sda) begin
                chk("start_outside_frame", 32'(in_frame), 0);
                in_frame = 1'b1;
                bitcnt   = 0;
                byte_idx = 0;
            end else begin
                // The STOP's own SCL rise was logged as a provisional 0 bit.
                chk("stop_at_byte_boundary", {30'd0, bitcnt == 1, shreg[0]}, 2'b10);
                in_frame = 1'b0;
                bitcnt   = 0;
                frame_idx++;
            end
        end
        if (!prev_scl && s_scl) begin
            chk("oen_low_only_in_ack", 32'(s_oen), 32'(bitcnt != 8));
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], s_sda};
                bitcnt++;
                if (bitcnt == 8) byte_done();
            end else begin
                chk("ack_level", 32'(s_sda), 32'(slave_nack));
                bitcnt = 0;
                byte_idx++;
            end
        end
        if (s_oen !== prev_oen) chk("oen_edge_with_scl_low", 32'(s_scl), 0);
        prev_scl = s_scl;
        prev_sda = s_sda;
        prev_oen = s_oen;
    endtask

    task automatic start_run(input int m);
        mode        = m;
        nacked_once = 1'b0;
        frame_idx   = 0;
        start       = 1'b1;
        step();
        start       = 1'b0;
        chk("busy_after_start", {29'd0, busy, finished, error}, 3'b100);
    endtask

    task automatic wait_end(input int lat0, output int lat);
        lat = lat0;
        while (!(finished || error) && lat < BOUND) begin
            step();
            lat++;
        end
        chk("run_ends_in_bound", 32'(lat < BOUND), 1);
    endtask

    int  lat;
    bit  found;

    initial begin
        tbl[0]   = 16'h0097;
        tbl[1]   = 16'h0297;
        rst_n    = 1'b0;
        start    = 1'b0;
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        prev_oen = 1'b1;
        in_frame = 1'b0;
        bitcnt   = 0;
        byte_idx = 0;
        mode     = 0;
        repeat (3) step();
        chk("reset_scl_sda_oen", {29'd0, scl, sda, oen}, 3'b111);
        chk("reset_flags", {29'd0, busy, finished, error}, 3'b000);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_fail_idx", fail_idx, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // Clean run, then a start pulse that lands on the DONE cycle.
        push_word(0);
        push_word(1);
        start_run(0);
        wait_end(0, lat);
        chk("clean_latency", lat, CLEAN_LAT);
        chk("clean_status", {29'd0, finished, error, busy}, 3'b100);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_on_done_ignored", {30'd0, busy, finished}, 2'b01);
        chk("clean_sb_empty", exp_q.size(), 0);
        repeat (20) step();

        // Start pulse mid-run is ignored.
        push_word(0);
        push_word(1);
        start_run(0);
        repeat (700) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_end(701, lat);
        chk("midstart_latency", lat, CLEAN_LAT);
        chk("midstart_status", {29'd0, finished, error, busy}, 3'b100);
        chk("midstart_sb_empty", exp_q.size(), 0);
        repeat (20) step();

        // One NACK on byte 1 of word 0: frame cut short, word resent.
        exp_q.push_back(ADDR_BYTE);
        exp_q.push_back(tbl[0][15:8]);
        push_word(0);
        push_word(1);
        start_run(1);
        wait_end(0, lat);
        chk("nack1_latency", lat, CLEAN_LAT + FAIL_ATT);
        chk("nack1_status", {29'd0, finished, error, busy}, 3'b100);
        chk("nack1_sb_empty", exp_q.size(), 0);
        repeat (20) step();

        // Word 1 address always NACKed: 1 + MAX_RETRY attempts, then error.
        push_word(0);
        repeat (3) exp_q.push_back(ADDR_BYTE);
        start_run(2);
        wait_end(0, lat);
        chk("persist_status", {29'd0, finished, error, busy}, 3'b010);
        chk("persist_fail_idx", fail_idx, 1);
        chk("persist_attempt_frames", frame_idx, 4);
        step();
        chk("persist_idle", {30'd0, busy, error}, 2'b01);
        chk("persist_sb_empty", exp_q.size(), 0);
        repeat (20) step();

        // Asynchronous reset during bit 5 of byte 1.
        push_word(0);
        push_word(1);
        start_run(0);
        found = 1'b0;
        for (int i = 0; i < BOUND && !found; i++) begin
            step();
            if (in_frame && byte_idx == 1 && bitcnt == 5) found = 1'b1;
        end
        chk("reached_bit5", 32'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_bus", {30'd0, scl, sda}, 2'b11);
        chk("async_reset_busy", {30'd0, busy, oen}, 2'b01);
        exp_q.delete();
        prev_scl = scl;
        prev_sda = sda;
        prev_oen = oen;
        in_frame = 1'b0;
        bitcnt   = 0;
        byte_idx = 0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        push_word(0);
        push_word(1);
        start_run(0);
        wait_end(0, lat);
        chk("post_reset_latency", lat, CLEAN_LAT);
        chk("post_reset_status", {29'd0, finished, error, busy}, 3'b100);
        chk("post_reset_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
